// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN streaming stages.
//   PIX_W / FMAP_W / FMAP_H : default pixel width and feature-map size
//   pix_t                   : one pixel
//   max2()                  : larger of two pixels, signed or unsigned compare
package cnn_pkg;

  localparam int PIX_W  = 16;
  localparam int FMAP_W = 6;
  localparam int FMAP_H = 6;

  typedef logic [PIX_W-1:0] pix_t;

  function automatic pix_t max2(input pix_t a, input pix_t b, input logic is_signed);
    logic a_gt;
    if (is_signed) a_gt = ($signed(a) > $signed(b));
    else           a_gt = (a > b);
    return a_gt ? a : b;
  endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Valid/ready pixel stream with an end-of-frame marker.
//   valid : producer has a pixel
//   ready : consumer takes it this cycle
//   data  : pixel
//   last  : final pixel of the frame
interface maxpool2x2_stream_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = PIX_W
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/maxpool_linebuf.sv
// Half-row buffer holding the horizontal pair maxima of the previous even row.
//   clk     : clock
//   wr_en   : write wr_data at wr_addr
//   wr_addr : pair index (col >> 1)
//   wr_data : pair maximum
//   rd_addr : pair index to read
//   rd_data : combinational read data
// Contents are not reset; every entry is rewritten before it is read in a frame.
module maxpool_linebuf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 3,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over one raster-order feature map.
//   clk       : clock
//   rst       : synchronous active-high reset
//   px        : input pixel stream (slave)
//   pool      : pooled pixel stream (master), one output register
//   frame_err : sticky, set when px.last disagrees with the pixel position
module maxpool2x2_stream
  import cnn_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int IMG_W  = FMAP_W,
  parameter int IMG_H  = FMAP_H,
  parameter bit SIGNED = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  maxpool2x2_stream_if.slave          px,
  maxpool2x2_stream_if.master         pool,
  output logic                        frame_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pix_t          hold;
  pix_t          pair_max;
  pix_t          rowbuf_rd;
  pix_t          win_max;
  logic          accept;
  logic          at_end;
  logic          rowbuf_we;
  logic [AW-1:0] rowbuf_addr;
  logic          out_valid;
  pix_t          out_data;
  logic          out_last;

  // Output slot is free when empty or draining this cycle, so load and drain may overlap.
  assign px.ready    = ~rst & (~out_valid | pool.ready);
  assign accept      = px.valid & px.ready;
  assign at_end      = (row == ROW_LAST) && (col == COL_LAST);
  assign rowbuf_addr = AW'(col >> 1);
  assign pair_max    = max2(hold, px.data, SIGNED);
  assign win_max     = max2(rowbuf_rd, pair_max, SIGNED);
  assign rowbuf_we   = accept & col[0] & ~row[0];

  maxpool_linebuf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W / 2),
    .AW     (AW)
  ) u_linebuf (
    .clk     (clk),
    .wr_en   (rowbuf_we),
    .wr_addr (rowbuf_addr),
    .wr_data (pair_max),
    .rd_addr (rowbuf_addr),
    .rd_data (rowbuf_rd)
  );

  // An early last resyncs to a frame start; a missing last only flags and wraps normally.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      frame_err <= 1'b0;
    end else if (accept) begin
      if (px.last && !at_end) begin
        col       <= '0;
        row       <= '0;
        frame_err <= 1'b1;
      end else begin
        if (!px.last && at_end) frame_err <= 1'b1;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !col[0]) hold <= px.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept && col[0] && row[0]) begin
      out_valid <= 1'b1;
      out_data  <= win_max;
      out_last  <= at_end;
    end else if (pool.ready) begin
      out_valid <= 1'b0;
    end
  end

  assign pool.valid = out_valid;
  assign pool.data  = out_data;
  assign pool.last  = out_last;

endmodule
